// File: rtl/alu_exec_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_exec_stage_pkg
// Shared definitions for the ALU execute stage:
//   - DATA_W / ADDR_W / MUL_STEPS width and length constants
//   - opcode_e    : instruction opcode encoding
//   - state_e     : execute-stage FSM state encoding
//   - alu_result_t: single-cycle ALU result (value + carry/borrow)
//   - alu_compute : combinational evaluation of the single-cycle opcodes
// -----------------------------------------------------------------------------
package alu_exec_stage_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 3;
    localparam int MUL_STEPS = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MOV = 3'd5,
        OP_SHL = 3'd6,
        OP_MUL = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              carry;
    } alu_result_t;

    // Single-cycle opcodes. MUL is handled by the sequential multiplier, so it
    // yields zero here and is never selected by the caller.
    function automatic alu_result_t alu_compute(input opcode_e           op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        alu_result_t     r;
        logic [DATA_W:0] sum;
        r.res   = '0;
        r.carry = 1'b0;
        sum     = '0;
        case (op)
            OP_ADD: begin
                sum     = {1'b0, a} + {1'b0, b};
                r.res   = sum[DATA_W-1:0];
                r.carry = sum[DATA_W];
            end
            OP_SUB: begin
                r.res   = a - b;
                r.carry = (a < b);   // borrow out
            end
            OP_AND:  r.res = a & b;
            OP_OR:   r.res = a | b;
            OP_XOR:  r.res = a ^ b;
            OP_MOV:  r.res = a;
            OP_SHL:  r.res = a << b[3:0];
            default: r.res = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// -----------------------------------------------------------------------------
// alu_exec_stage_if
// Bundles the instruction handshake, register-file read/write ports, status
// flags and FSM debug state of the ALU execute stage.
//   slave  : the execute stage itself
//   master : the instruction issuer plus register file (testbench side)
//
// Handshake: an instruction (op/dst/srcA/srcB) transfers on the rising edge
// where instr_valid && instr_ready are both high. instr_valid may be held or
// dropped freely; while instr_ready is low the offered fields are ignored.
// write is a single-cycle strobe; wrAddr/wrData are valid while it is high.
// -----------------------------------------------------------------------------
interface alu_exec_stage_if;
    import alu_exec_stage_pkg::*;

    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        op;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] srcA;
    logic [ADDR_W-1:0] srcB;
    logic [ADDR_W-1:0] rdAddrA;
    logic [ADDR_W-1:0] rdAddrB;
    logic [DATA_W-1:0] rdDataA;
    logic [DATA_W-1:0] rdDataB;
    logic              write;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;
    logic              zero;
    logic              carry;
    state_e            state_dbg;

    modport slave (
        input  instr_valid, op, dst, srcA, srcB, rdDataA, rdDataB,
        output instr_ready, rdAddrA, rdAddrB, write, wrAddr, wrData,
               zero, carry, state_dbg
    );

    modport master (
        output instr_valid, op, dst, srcA, srcB, rdDataA, rdDataB,
        input  instr_ready, rdAddrA, rdAddrB, write, wrAddr, wrData,
               zero, carry, state_dbg
    );

endinterface

// File: rtl/alu_exec_stage_mul16.sv
// -----------------------------------------------------------------------------
// mul16_seq
// Unsigned shift-add multiplier producing the low 16 bits of A*B in exactly
// MUL_STEPS cycles after the start cycle.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : load a_i/b_i and clear the accumulator on this edge
//   a_i, b_i      : operands
//   done_o        : high during the final step; product_o is valid then
//   product_o     : low 16 bits of the product (includes the final step)
// -----------------------------------------------------------------------------
module mul16_seq
    import alu_exec_stage_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] step_sum;
    logic              busy;

    assign busy     = (cnt_q != 5'd0);
    assign step_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = 5'(MUL_STEPS);
        end else if (busy) begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 5'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Exposing the in-flight sum lets the caller capture the result on the
    // same edge as the last step, keeping the MUL phase at exactly 16 cycles.
    assign done_o    = (cnt_q == 5'd1);
    assign product_o = step_sum;

endmodule

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
// Multi-cycle ALU execute stage: accepts one instruction in IDLE, reads its
// operands from the register file during EXEC, optionally runs the sequential
// multiplier in MUL, then writes the result back during WB.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu_exec_stage_if.slave (handshake, register-file ports, flags,
//            FSM debug state)
// -----------------------------------------------------------------------------
module alu_exec_stage
    import alu_exec_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    alu_exec_stage_if.slave  bus
);

    state_e            state_q, state_d;
    opcode_e           op_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_b_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;   // doubles as the result register
    logic              res_carry_q;
    logic              zero_q, carry_q;

    logic              accept;
    logic              ready_s, write_s, mul_start;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;
    alu_result_t       alu_res;

    assign accept  = bus.instr_valid && (state_q == ST_IDLE);
    assign alu_res = alu_compute(op_q, bus.rdDataA, bus.rdDataB);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = (op_q == OP_MUL) ? ST_MUL : ST_WB;
            ST_MUL:  if (mul_done) state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready_s   = 1'b0;
        write_s   = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: ready_s   = 1'b1;
            ST_EXEC: mul_start = (op_q == OP_MUL);
            // Upper half of the address space is not writable; WB still runs
            // so the flags track every completed instruction.
            ST_WB:   write_s   = !dst_q[2];
            default: ;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OP_ADD;
            dst_q       <= '0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            res_carry_q <= 1'b0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            if (accept) begin
                op_q        <= opcode_e'(bus.op);
                dst_q       <= bus.dst;
                rd_addr_a_q <= bus.srcA;
                rd_addr_b_q <= bus.srcB;
            end
            // Write address/data only move on entry to WB, so they stay
            // stable through WB and hold afterwards.
            if (state_q == ST_EXEC && op_q != OP_MUL) begin
                wr_data_q   <= alu_res.res;
                res_carry_q <= alu_res.carry;
                wr_addr_q   <= dst_q;
            end
            if (state_q == ST_MUL && mul_done) begin
                wr_data_q   <= mul_product;
                res_carry_q <= 1'b0;
                wr_addr_q   <= dst_q;
            end
            if (state_q == ST_WB) begin
                zero_q  <= (wr_data_q == '0);
                carry_q <= res_carry_q;
            end
        end
    end

    mul16_seq u_mul (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (mul_start),
        .a_i       (bus.rdDataA),
        .b_i       (bus.rdDataB),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    assign bus.instr_ready = ready_s;
    assign bus.write       = write_s;
    assign bus.rdAddrA     = rd_addr_a_q;
    assign bus.rdAddrB     = rd_addr_b_q;
    assign bus.wrAddr      = wr_addr_q;
    assign bus.wrData      = wr_data_q;
    assign bus.zero        = zero_q;
    assign bus.carry       = carry_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    logic [15:0] rf[4];      // register file seen by the DUT
    logic [15:0] exp_rf[4];  // reference-model register file

    alu_exec_stage_if bus();

    alu_exec_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Addresses 4-7 read as zero.
    assign bus.rdDataA = bus.rdAddrA[2] ? 16'h0000 : rf[bus.rdAddrA[1:0]];
    assign bus.rdDataB = bus.rdAddrB[2] ? 16'h0000 : rf[bus.rdAddrB[1:0]];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [16:0] ref_alu(input int op, input longint a, input longint b);
        longint r;
        logic   c;
        c = 1'b0;
        case (op)
            0: begin r = a + b; c = (r > 65535); end
            1: begin r = a - b; c = (a < b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a;
            6: r = a << (b % 16);
            default: r = a * b;
        endcase
        return {c, r[15:0]};
    endfunction

    function automatic longint rdval(input logic [2:0] a);
        return a[2] ? 64'd0 : longint'(exp_rf[a[1:0]]);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".write"},   32'(bus.write),   32'd0);
        check({tag, ".wrAddr"},  32'(bus.wrAddr),  32'd0);
        check({tag, ".wrData"},  32'(bus.wrData),  32'd0);
        check({tag, ".rdAddrA"}, 32'(bus.rdAddrA), 32'd0);
        check({tag, ".rdAddrB"}, 32'(bus.rdAddrB), 32'd0);
        check({tag, ".zero"},    32'(bus.zero),    32'd0);
        check({tag, ".carry"},   32'(bus.carry),   32'd0);
        check({tag, ".ready"},   32'(bus.instr_ready), 32'd1);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [2:0] addr, input logic [15:0] val);
        if (!addr[2]) begin
            rf[addr[1:0]]     = val;
            exp_rf[addr[1:0]] = val;
        end
    endtask

    // Issues one instruction and follows it to completion. With junk set,
    // random instructions are offered while the stage is busy.
    task automatic run_instr(input string tag, input logic [2:0] op, input logic [2:0] dst,
                             input logic [2:0] sa, input logic [2:0] sb,
                             input logic [15:0] exp_data, input logic exp_z,
                             input logic exp_c, input bit junk);
        int          k, nw, wk, exp_lat;
        logic [2:0]  wa;
        logic [15:0] wd;
        exp_lat = (op == 3'd7) ? 18 : 2;
        k = 0;
        while (!bus.instr_ready && k < 40) begin
            tick();
            k++;
        end
        check({tag, ".ready_in"}, 32'(bus.instr_ready), 32'd1);
        bus.instr_valid = 1'b1;
        bus.op   = op;
        bus.dst  = dst;
        bus.srcA = sa;
        bus.srcB = sb;
        tick();  // accept edge
        check({tag, ".rdAddrA"}, 32'(bus.rdAddrA), 32'(sa));
        check({tag, ".rdAddrB"}, 32'(bus.rdAddrB), 32'(sb));
        bus.instr_valid = junk;
        if (junk) begin
            bus.op   = 3'($urandom_range(0, 7));
            bus.dst  = 3'($urandom_range(0, 7));
            bus.srcA = 3'($urandom_range(0, 7));
            bus.srcB = 3'($urandom_range(0, 7));
        end
        nw = 0; wk = -1; wa = '0; wd = '0;
        for (k = 1; k <= 40; k++) begin
            tick();
            if (bus.write) begin
                nw++;
                wk = k;
                wa = bus.wrAddr;
                wd = bus.wrData;
                rf[wa[1:0]] = wd;
            end
            if (bus.instr_ready) begin
                bus.instr_valid = 1'b0;
                break;
            end
        end
        bus.instr_valid = 1'b0;
        check({tag, ".latency"}, 32'(k), 32'(exp_lat));
        if (dst[2]) begin
            check({tag, ".nwrites"}, 32'(nw), 32'd0);
        end else begin
            check({tag, ".nwrites"},  32'(nw), 32'd1);
            check({tag, ".wr_cycle"}, 32'(wk), 32'(exp_lat - 1));
            check({tag, ".wrAddr"},   32'(wa), 32'(dst));
            check({tag, ".wrData"},   32'(wd), 32'(exp_data));
            exp_rf[dst[1:0]] = exp_data;
        end
        check({tag, ".zero"},  32'(bus.zero),  32'(exp_z));
        check({tag, ".carry"}, 32'(bus.carry), 32'(exp_c));
    endtask

    // instr_valid held high across back-to-back ADDs.
    task automatic back_to_back();
        logic [18:0] exp_q[$];
        logic [18:0] e;
        logic [16:0] r;
        logic [2:0]  d, a, b;
        logic        pre;
        int          acc, wr, cyc, last_acc;
        for (int j = 0; j < 4; j++) preload(3'(j), 16'($urandom()));
        acc = 0; wr = 0; cyc = 0; last_acc = -1;
        d = 3'($urandom_range(0, 3)); a = 3'($urandom_range(0, 3)); b = 3'($urandom_range(0, 3));
        bus.op = 3'd0; bus.dst = d; bus.srcA = a; bus.srcB = b;
        bus.instr_valid = 1'b1;
        while (wr < 4 && cyc < 60) begin
            pre = bus.instr_ready && bus.instr_valid;
            tick();
            cyc++;
            if (bus.write) begin
                wr++;
                rf[bus.wrAddr[1:0]] = bus.wrData;
                if (exp_q.size() == 0) begin
                    check("b2b.unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("b2b.write", 32'({bus.wrAddr, bus.wrData}), 32'(e));
                end
            end
            if (pre) begin
                if (last_acc >= 0) check("b2b.accept_gap", 32'(cyc - last_acc), 32'd3);
                last_acc = cyc;
                r = ref_alu(0, rdval(a), rdval(b));
                exp_q.push_back({d, r[15:0]});
                exp_rf[d[1:0]] = r[15:0];
                acc++;
                if (acc == 4) begin
                    bus.instr_valid = 1'b0;
                end else begin
                    d = 3'($urandom_range(0, 3)); a = 3'($urandom_range(0, 3)); b = 3'($urandom_range(0, 3));
                    bus.dst = d; bus.srcA = a; bus.srcB = b;
                end
            end
        end
        bus.instr_valid = 1'b0;
        check("b2b.accepts", 32'(acc), 32'd4);
        check("b2b.writes",  32'(wr),  32'd4);
    endtask

    // Reset pulse during the eighth MUL cycle.
    task automatic reset_during_mul();
        int nw;
        preload(3'd1, 16'h0123);
        preload(3'd2, 16'h0010);
        bus.instr_valid = 1'b1;
        bus.op = 3'd7; bus.dst = 3'd2; bus.srcA = 3'd1; bus.srcB = 3'd2;
        tick();  // accept
        bus.instr_valid = 1'b0;
        repeat (8) tick();  // now inside MUL cycle 8
        #2 rst_n = 1'b0;
        #1 check_reset("rst_mul.during");
        tick();
        check_reset("rst_mul.held");
        rst_n = 1'b1;
        nw = 0;
        for (int k = 0; k < 24; k++) begin
            tick();
            if (bus.write) nw++;
        end
        check("rst_mul.no_write", 32'(nw), 32'd0);
        check("rst_mul.ready",    32'(bus.instr_ready), 32'd1);
        preload(3'd1, 16'h1111);
        preload(3'd2, 16'h2222);
        run_instr("rst_mul.add", 3'd0, 3'd3, 3'd1, 3'd2, 16'h3333, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]  op;
        logic [2:0]  dst;
        logic [2:0]  sa;
        logic [2:0]  sb;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_data;
        logic        exp_z;
        logic        exp_c;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [2:0]  op, dst, sa, sb;
        logic [16:0] r;

        n_cmp = 0;
        n_fail = 0;
        for (int j = 0; j < 4; j++) begin
            rf[j] = '0;
            exp_rf[j] = '0;
        end
        bus.instr_valid = 1'b0;
        bus.op = '0; bus.dst = '0; bus.srcA = '0; bus.srcB = '0;

        //               op    dst   sa    sb    A         B         result    z     c
        vecs[0]  = '{3'd0, 3'd3, 3'd1, 3'd2, 16'h0003, 16'h0005, 16'h0008, 1'b0, 1'b0};
        vecs[1]  = '{3'd0, 3'd0, 3'd1, 3'd2, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
        vecs[2]  = '{3'd1, 3'd0, 3'd2, 3'd1, 16'h0001, 16'hFFFF, 16'h0002, 1'b0, 1'b1};
        vecs[3]  = '{3'd1, 3'd1, 3'd2, 3'd3, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};
        vecs[4]  = '{3'd7, 3'd2, 3'd1, 3'd2, 16'h0123, 16'h0010, 16'h1230, 1'b0, 1'b0};
        vecs[5]  = '{3'd6, 3'd3, 3'd1, 3'd2, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0};
        vecs[6]  = '{3'd5, 3'd5, 3'd1, 3'd2, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0};
        vecs[7]  = '{3'd2, 3'd0, 3'd1, 3'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0};
        vecs[8]  = '{3'd3, 3'd3, 3'd1, 3'd2, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0};
        vecs[9]  = '{3'd4, 3'd2, 3'd1, 3'd2, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{3'd0, 3'd6, 3'd1, 3'd2, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        vecs[11] = '{3'd7, 3'd1, 3'd1, 3'd2, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0};
        vecs[12] = '{3'd6, 3'd0, 3'd1, 3'd2, 16'h8001, 16'h0001, 16'h0002, 1'b0, 1'b0};
        vecs[13] = '{3'd0, 3'd1, 3'd5, 3'd6, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};

        // Power-on reset.
        rst_n = 1'b0;
        repeat (2) tick();
        check_reset("por");
        rst_n = 1'b1;
        tick();
        check("por.ready_after", 32'(bus.instr_ready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            preload(vecs[i].sa, vecs[i].a);
            preload(vecs[i].sb, vecs[i].b);
            run_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].dst, vecs[i].sa, vecs[i].sb,
                      vecs[i].exp_data, vecs[i].exp_z, vecs[i].exp_c, (i % 2) == 1);
        end

        back_to_back();
        reset_during_mul();

        // Random instructions against the reference model.
        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) begin
                for (int j = 0; j < 4; j++) preload(3'(j), 16'($urandom()));
            end
            op  = 3'($urandom_range(0, 7));
            dst = 3'($urandom_range(0, 7));
            sa  = 3'($urandom_range(0, 7));
            sb  = 3'($urandom_range(0, 7));
            r   = ref_alu(int'(op), rdval(sa), rdval(sb));
            run_instr($sformatf("rnd%0d", i), op, dst, sa, sb, r[15:0], (r[15:0] == 16'h0000),
                      r[16], ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have no parameters; widths fixed: data 16 bits, register address 3 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr_valid  input  1  instruction offered this cycle.
REQ-005 instr_ready  output  1  stage can accept an instruction (high only in IDLE).
REQ-006 op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV, 6 SHL, 7 MUL.
REQ-007 dst, srcA, srcB  input  3 each  destination and source register addresses.
REQ-008 rdAddrA, rdAddrB  output  3 each  register-file read addresses, registered.
REQ-009 rdDataA, rdDataB  input  16 each  combinational register-file read data.
REQ-010 write  output  1  one-cycle write strobe to the register file.
REQ-011 wrAddr  output  3  write address; wrData  output  16  write data.
REQ-012 zero, carry  output  1 each  status flags from the last completed instruction.

Function
REQ-013 FSM states IDLE, EXEC, MUL, WB; instr_ready = (state == IDLE).
REQ-014 Accept at the rising edge where instr_valid && instr_ready: latch op and dst; load rdAddrA/rdAddrB with srcA/srcB; go to EXEC.
REQ-015 instr_valid while not ready: no effect, no latching.
REQ-016 EXEC (one cycle): for ops 0-6, compute from rdDataA (A) and rdDataB (B), register the result, go to WB; for MUL, capture A and B into the multiplier and go to MUL.
REQ-017 ADD: {carry,res} = A+B; SUB: res = A-B, carry = borrow (A<B unsigned); AND/OR/XOR bitwise; MOV: res = A; SHL: res = A << B[3:0]; for ops 2-7, carry = 0.
REQ-018 MUL: unsigned shift-add over exactly 16 cycles in MUL; res = low 16 bits of A*B; then go to WB.
REQ-019 WB (one cycle): write = 1, wrAddr = dst, wrData = res; zero = (res == 0) and carry update at the end of WB; next state IDLE.
REQ-020 dst[2] = 1 (address 4-7): WB still occurs and flags update, but write stays 0.
REQ-021 Latency: accept edge E0 -> write high from E1 to E2 for ops 0-6; from E17 to E18 for MUL; instr_ready returns high after the WB edge.
REQ-022 Sources with address 4-7 read as whatever the register file returns (0); no special handling.
REQ-023 write is 0 in every state except WB; wrAddr/wrData hold their last values outside WB.

Reset
REQ-024 While rst_n = 0: state IDLE, write 0, wrAddr 0, wrData 0, rdAddrA/rdAddrB 0, zero 0, carry 0, multiplier state 0; instr_ready = 1 after release.
REQ-025 Reset asserted in EXEC, MUL or WB aborts the instruction immediately with no write; the first post-reset handshake is handled normally.

Structure
REQ-026 Shared package SHALL hold the opcode encodings, the FSM state encoding and the data-width constant (16).
REQ-027 The sequential multiplier SHALL be the sub-module mul16_seq (start, A, B in; done, product[15:0] out); all other logic is inline.

Verification
REQ-028 Preload r1 = 0x0003, r2 = 0x0005; ADD dst 3, srcA 1, srcB 2 -> write at E1, wrAddr 3, wrData 0x0008, zero 0, carry 0.
REQ-029 r1 = 0xFFFF, r2 = 0x0001; ADD dst 0 -> wrData 0x0000, zero 1, carry 1; SUB r2 - r1 -> wrData 0x0002, carry 1.
REQ-030 r1 = 0x0123, r2 = 0x0010; MUL dst 2 -> instr_ready low 18 cycles, single write at E17, wrData 0x1230.
REQ-031 SHL r1 = 0x0001, r2 = 0x0013 -> wrData 0x0008 (shift count 3); MOV dst 5 -> no write strobe, instr_ready high after 2 cycles.
REQ-032 rst_n pulsed low during MUL cycle 8 -> write never asserts, all outputs at reset values, next ADD completes correctly.
REQ-033 instr_valid held high continuously with back-to-back ADDs -> accepts exactly one per 3 cycles, writes in order.
